// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encodings and opcode screening for the ALU scheduler.
package alu_pkg;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MULT  = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_RESET = 4'hF;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Opcode-only screen; the DIV-by-zero case also needs operand B, so the caller checks that.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_NOT) || (op == OP_RESET);
  endfunction

endpackage

// File: rtl/alu_rr_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt          = '0;
        gnt[idx]     = 1'b1;
        gnt_idx      = PW'(idx);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one accumulator ALU between N requesters; one op per 3 cycles,
// response held until the granted requester asserts resp_ready.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [4*N-1:0] req_op,
  input  logic [W*N-1:0] req_a,
  input  logic [W*N-1:0] req_b,
  output logic [N-1:0]   resp_valid,
  input  logic [N-1:0]   resp_ready,
  output logic [W-1:0]   resp_data,
  output logic           resp_err,
  output logic [3:0]     alu_opcode,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  input  logic [W-1:0]   alu_out
);

  localparam int PW = $clog2(N);

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q;
  logic [N-1:0]  gnt_q;
  logic [PW-1:0] gnt_idx_q;
  logic [3:0]    op_q;
  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  resp_data_q;
  logic          resp_err_q;

  logic [N-1:0]  arb_gnt;
  logic [PW-1:0] arb_idx;
  logic          arb_any;
  logic [3:0]    sel_op;
  logic [W-1:0]  sel_a, sel_b;
  logic          sel_illegal;
  logic          resp_hs;

  rr_arbiter #(.N(N), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) begin
        sel_op = req_op[4*i +: 4];
        sel_a  = req_a[W*i +: W];
        sel_b  = req_b[W*i +: W];
      end
    end
  end

  assign sel_illegal = !op_is_legal(sel_op) || ((sel_op == OP_DIV) && (sel_b == '0));
  // resp_ready on any index other than the granted one has no effect.
  assign resp_hs     = |(resp_ready & gnt_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_IDLE;
      ST_IDLE:  if (arb_any) state_d = sel_illegal ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  if (resp_hs) state_d = ST_IDLE;
      default:  state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_q     <= arb_gnt;
            gnt_idx_q <= arb_idx;
            op_q      <= sel_op;
            a_q       <= sel_a;
            b_q       <= sel_b;
            if (sel_illegal) begin
              resp_data_q <= '0;
              resp_err_q  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          resp_data_q <= alu_out;
          resp_err_q  <= 1'b0;
        end
        ST_RESP: begin
          if (resp_hs) ptr_q <= (gnt_idx_q == PW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced to zero while rst is high so an op caught mid-ISSUE never reaches the ALU.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    resp_data  = '0;
    resp_err   = 1'b0;
    alu_opcode = OP_NOOP;
    alu_in1    = '0;
    alu_in2    = '0;
    if (!rst) begin
      resp_data = resp_data_q;
      resp_err  = resp_err_q;
      case (state_q)
        ST_INIT:  alu_opcode = OP_RESET;
        ST_IDLE:  req_ready  = arb_gnt;
        ST_ISSUE: begin
          alu_opcode = op_q;
          alu_in1    = a_q;
          alu_in2    = b_q;
        end
        ST_RESP:  resp_valid = gnt_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched with a behavioural accumulator ALU, N=4, W=16.
module tb_alu_rr_sched;

  localparam logic [3:0] C_NOOP = 4'h0;
  localparam logic [3:0] C_ADD  = 4'h1;
  localparam logic [3:0] C_SUB  = 4'h2;
  localparam logic [3:0] C_MULT = 4'h3;
  localparam logic [3:0] C_DIV  = 4'h4;
  localparam logic [3:0] C_XOR  = 4'h7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] req_op = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready = '0;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [15:0] acc = 16'hbeef;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_div  = 1'b0;
  int div_seen = 0;

  always #5 clk = ~clk;

  alu_rr_sched #(.W(16), .N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .alu_opcode (alu_opcode),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out)
  );

  // Accumulator ALU: alu_out is the value the accumulator loads at the next edge.
  always_comb begin
    case (alu_opcode)
      4'h1:    alu_out = alu_in1 + alu_in2;
      4'h2:    alu_out = alu_in1 - alu_in2;
      4'h3:    alu_out = 16'(alu_in1 * alu_in2);
      4'h4:    alu_out = (alu_in2 != 0) ? alu_in1 / alu_in2 : acc;
      4'h5:    alu_out = alu_in1 & alu_in2;
      4'h6:    alu_out = alu_in1 | alu_in2;
      4'h7:    alu_out = alu_in1 ^ alu_in2;
      4'h8:    alu_out = ~alu_in1;
      4'hF:    alu_out = '0;
      default: alu_out = acc;
    endcase
  end

  always @(posedge clk) acc <= alu_out;

  always @(negedge clk) if (mon_div && alu_opcode == C_DIV) div_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    req_op[4*i +: 4]  = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp);
    int n = 0;
    #1;
    while (req_ready == 0 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_resp(input string tag, input int idx, input logic [15:0] exp_data,
                           input logic exp_err, input int holdoff);
    int n = 0;
    logic [3:0] oh;
    oh = 4'(1 << idx);
    while (resp_valid == 0 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, 32'(resp_valid), 32'(oh));
    check({tag, "_data"}, 32'(resp_data), 32'(exp_data));
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    for (int h = 0; h < holdoff; h++) begin
      resp_ready = ~oh;
      tick();
      check({tag, "_hold_vld"}, 32'(resp_valid), 32'(oh));
      check({tag, "_hold_data"}, 32'(resp_data), 32'(exp_data));
    end
    resp_ready = oh;
    #1;
    check({tag, "_hs_noready"}, 32'(req_ready), 32'h0);
    tick();
    resp_ready = '0;
    #1;
    check({tag, "_vld_drop"}, 32'(resp_valid), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, INIT pulse, accumulator cleared
    tick();
    tick();
    check("rst_opcode", 32'(alu_opcode), 32'h0);
    check("rst_rdy", 32'(req_ready), 32'h0);
    check("rst_vld", 32'(resp_valid), 32'h0);
    check("rst_data", 32'(resp_data), 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    check("rst_in1", 32'(alu_in1), 32'h0);
    rst = 1'b0;
    #1;
    check("init_opcode", 32'(alu_opcode), 32'hF);
    tick();
    check("init_acc", 32'(acc), 32'h0);
    check("idle_opcode", 32'(alu_opcode), 32'h0);

    // 2: single ADD with exact latency
    set_req(0, C_ADD, 16'd1, 16'd1);
    #1;
    check("add_rdy", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check("add_rdy_pulse", 32'(req_ready), 32'h0);
    check("add_issue_op", 32'(alu_opcode), 32'(C_ADD));
    check("add_issue_in1", 32'(alu_in1), 32'h1);
    check("add_issue_in2", 32'(alu_in2), 32'h1);
    tick();
    check("add_lat_vld", 32'(resp_valid), 32'h1);
    wait_resp("add", 0, 16'd2, 1'b0, 0);

    // requester 3 XOR moves the pointer through the N-1 -> 0 wrap
    set_req(3, C_XOR, 16'h0005, 16'h0003);
    wait_grant("xor_gnt", 4'h8);
    tick();
    req_valid = '0;
    wait_resp("xor", 3, 16'h0006, 1'b0, 0);

    // 3: all four requesters contend with MULT 2*2
    for (int i = 0; i < 4; i++) set_req(i, C_MULT, 16'd2, 16'd2);
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("mult_gnt%0d", k), 4'(1 << (k % 4)));
      tick();
      if (k == 4) req_valid = '0;
      wait_resp($sformatf("mult%0d", k), k % 4, 16'd4, 1'b0, (k == 0) ? 5 : 0);
    end

    // 4: DIV by zero is screened and never reaches the ALU
    mon_div = 1'b1;
    set_req(2, C_DIV, 16'd8, 16'd0);
    wait_grant("div0_gnt", 4'h4);
    tick();
    req_valid = '0;
    wait_resp("div0", 2, 16'd0, 1'b1, 0);
    mon_div = 1'b0;
    check("div0_never_issued", 32'(div_seen), 32'h0);

    // 5: illegal opcode, then NOOP returns the accumulator left by MULT
    set_req(1, 4'hA, 16'd9, 16'd9);
    wait_grant("ill_gnt", 4'h2);
    tick();
    req_valid = '0;
    wait_resp("ill", 1, 16'd0, 1'b1, 0);
    set_req(1, C_NOOP, 16'd0, 16'd0);
    wait_grant("noop_gnt", 4'h2);
    tick();
    req_valid = '0;
    wait_resp("noop", 1, 16'd4, 1'b0, 0);

    // 6: reset lands in the ISSUE cycle of SUB
    set_req(0, C_SUB, 16'd3, 16'd1);
    wait_grant("sub_gnt", 4'h1);
    tick();
    req_valid = '0;
    #1;
    check("sub_issue_op", 32'(alu_opcode), 32'(C_SUB));
    rst = 1'b1;
    #1;
    check("sub_rst_gate", 32'(alu_opcode), 32'h0);
    tick();
    check("sub_rst_vld", 32'(resp_valid), 32'h0);
    check("sub_rst_acc", 32'(acc), 32'h4);
    rst = 1'b0;
    #1;
    check("rst2_init_op", 32'(alu_opcode), 32'hF);
    tick();
    check("rst2_vld", 32'(resp_valid), 32'h0);
    check("rst2_acc", 32'(acc), 32'h0);
    tick();
    check("rst2_no_resp", 32'(resp_valid), 32'h0);
    set_req(3, C_ADD, 16'd7, 16'd5);
    wait_grant("post_rst_gnt", 4'h8);
    tick();
    req_valid = '0;
    wait_resp("post_rst", 3, 16'd12, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
